gray_ramp_counter: RTL and testbench

Parametrised successor to the free-running Gray counter. It drives the shared Gray-coded ramp-count bus for the column single-slope ADCs.
Adds a start/run/done conversion FSM, a programmable terminal count with wrap or stop mode, and abort.
Gray output is registered, so it is glitch-free. The block fans out to several independently tristated column-bank buses.

---
 rtl/gray_ramp_if.sv | 25 ++
 rtl/gray_ramp_counter.sv | 86 ++++++++
 tb/tb_gray_ramp_counter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/gray_ramp_if.sv
// Control and status bundle for the Gray ramp counter.
// The tristated column-bank bus is a separate module port.
interface gray_ramp_if #(
  parameter int WIDTH = 8,
  parameter int BANKS = 2
);
  logic             start;
  logic             abort;
  logic             wrap_en;
  logic [WIDTH-1:0] limit;
  logic [BANKS-1:0] bank_en;
  logic [WIDTH-1:0] count_bin;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, wrap_en, limit, bank_en,
    input  count_bin, busy, done
  );

  modport slave (
    input  start, abort, wrap_en, limit, bank_en,
    output count_bin, busy, done
  );
endinterface

// File: rtl/gray_ramp_counter.sv
// Gray-coded ramp counter for column single-slope ADCs.
// Start/run/done FSM, terminal count with wrap or stop, abort.
module gray_ramp_counter #(
  parameter int WIDTH = 8,
  parameter int BANKS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  gray_ramp_if.slave             bus,
  output wire [BANKS*WIDTH-1:0]  gray_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] bin, bin_n;
  logic [WIDTH-1:0] limit_q, limit_n;
  logic [WIDTH-1:0] gray_q;
  logic             busy_q, done_q;

  always_comb begin
    state_n = state;
    bin_n   = bin;
    limit_n = limit_q;
    unique case (state)
      S_IDLE: begin
        if (!bus.abort && bus.start) begin
          bin_n   = '0;
          limit_n = bus.limit;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_n = S_IDLE;
        end else if (bin == limit_q) begin
          if (bus.wrap_en) bin_n = '0;
          else             state_n = S_DONE;
        end else begin
          bin_n = bin + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.abort) begin
          state_n = S_IDLE;
        end else if (bus.start) begin
          bin_n   = '0;
          limit_n = bus.limit;
          state_n = S_RUN;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Gray is encoded from bin_n so the bus comes straight off a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bin     <= '0;
      limit_q <= '0;
      gray_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      bin     <= bin_n;
      limit_q <= limit_n;
      gray_q  <= bin_n ^ (bin_n >> 1);
      busy_q  <= (state_n == S_RUN);
      done_q  <= (state_n == S_DONE);
    end
  end

  assign bus.count_bin = bin;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign gray_bus[b*WIDTH +: WIDTH] =
      bus.bank_en[b] ? gray_q : {WIDTH{1'bz}};
  end

endmodule

// File: tb/tb_gray_ramp_counter.sv
// Directed bench for gray_ramp_counter (WIDTH=8, BANKS=2).
// Bus net is pulled up, so a released bank reads all ones.
module tb_gray_ramp_counter;

  logic clk;
  logic reset;
  tri1 [15:0] gray_bus;

  gray_ramp_if #(.WIDTH(8), .BANKS(2)) bus ();

  gray_ramp_counter #(.WIDTH(8), .BANKS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .gray_bus (gray_bus)
  );

  wire [7:0] b0 = gray_bus[7:0];
  wire [7:0] b1 = gray_bus[15:8];

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic       start;
    logic       abort;
    logic       wrap;
    logic [7:0] limit;
    logic [7:0] bin;
    logic [7:0] gray;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] gtab[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] expb;
  logic [7:0] prev;

  initial begin
    n_chk  = 0;
    n_fail = 0;

    gtab = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07,
             8'h05, 8'h04, 8'h0C, 8'h0D, 8'h0F};
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'd10, 8'd0, 8'h00, 1'b1, 1'b0};
    for (int i = 1; i <= 10; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b0, 8'd99, 8'(i), gtab[i], 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd10, 8'd10, 8'h0F, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd10, 8'd10, 8'h0F, 1'b0, 1'b1};

    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.wrap_en = 1'b0;
    bus.limit   = 8'd0;
    bus.bank_en = 2'b01;
    reset       = 1'b1;

    #12;
    chk("rst_bin",  bus.count_bin, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_b0",   b0, 8'h00);
    chk("rst_b1z",  b1, 8'hFF);
    reset = 1'b0;

    // limit=10 stop mode; limit input is changed during RUN and ignored
    prev = 8'h00;
    for (int i = 0; i < 13; i++) begin
      bus.start   = vecs[i].start;
      bus.abort   = vecs[i].abort;
      bus.wrap_en = vecs[i].wrap;
      bus.limit   = vecs[i].limit;
      step();
      chk($sformatf("v%0d_bin", i),  bus.count_bin, vecs[i].bin);
      chk($sformatf("v%0d_gray", i), b0, vecs[i].gray);
      chk($sformatf("v%0d_b1z", i),  b1, 8'hFF);
      chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
      chk($sformatf("v%0d_done", i), bus.done, vecs[i].done);
      if (i >= 1 && i <= 10)
        chk($sformatf("v%0d_1bit", i), $countones(prev ^ b0), 1);
      prev = b0;
    end
    bus.start = 1'b0;

    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_done_busy", bus.busy, 0);
    chk("abort_done_done", bus.done, 0);
    chk("abort_done_bin",  bus.count_bin, 10);

    // async reset mid-ramp at 0x37
    bus.limit   = 8'd255;
    bus.wrap_en = 1'b0;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    step(55);
    chk("pre_rst_bin", bus.count_bin, 8'h37);
    reset = 1'b1;
    #1;
    chk("mid_rst_bin",  bus.count_bin, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_b0",   b0, 8'h00);
    chk("mid_rst_b1z",  b1, 8'hFF);
    #3;
    reset = 1'b0;
    step();

    // full-range modulo wrap for 600 cycles
    bus.limit   = 8'd255;
    bus.wrap_en = 1'b1;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    expb = 8'd0;
    chk("w255_start", bus.count_bin, 0);
    prev = b0;
    for (int i = 0; i < 600; i++) begin
      step();
      expb = expb + 8'd1;
      chk("w255_bin",  bus.count_bin, expb);
      chk("w255_gray", b0, expb ^ (expb >> 1));
      chk("w255_busy", bus.busy, 1);
      chk("w255_done", bus.done, 0);
      chk("w255_1bit", $countones(prev ^ b0), 1);
      if (expb == 8'd0) begin
        chk("w255_prev80", prev, 8'h80);
        chk("w255_zero",   b0, 8'h00);
      end
      prev = b0;
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;

    // limit=5 wrapping, then stop mode mid-run
    bus.limit   = 8'd5;
    bus.wrap_en = 1'b1;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    chk("w5_bin0", bus.count_bin, 0);
    for (int i = 1; i <= 13; i++) begin
      step();
      chk($sformatf("w5_bin%0d", i), bus.count_bin, i % 6);
    end
    bus.wrap_en = 1'b0;
    for (int e = 2; e <= 5; e++) begin
      step();
      chk("w5_tail_bin",  bus.count_bin, e);
      chk("w5_tail_busy", bus.busy, 1);
    end
    step();
    chk("w5_done",      bus.done, 1);
    chk("w5_done_busy", bus.busy, 0);
    chk("w5_done_bin",  bus.count_bin, 5);

    // restart from DONE, then abort+start together at count 7
    bus.limit = 8'd20;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("rs_bin",  bus.count_bin, 0);
    chk("rs_busy", bus.busy, 1);
    chk("rs_done", bus.done, 0);
    chk("rs_gray", b0, 8'h00);
    step(7);
    chk("rs_bin7", bus.count_bin, 7);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_done", bus.done, 0);
    chk("ab_bin",  bus.count_bin, 7);
    chk("ab_gray", b0, 8'h04);
    step(2);
    chk("ab_hold", bus.count_bin, 7);

    // bank enable sweep between clock edges at count 12
    bus.limit = 8'd200;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(12);
    chk("bk_bin", bus.count_bin, 12);
    bus.bank_en = 2'b00;
    #1;
    chk("bk00_b0", b0, 8'hFF);
    chk("bk00_b1", b1, 8'hFF);
    bus.bank_en = 2'b01;
    #1;
    chk("bk01_b0", b0, 8'h0A);
    chk("bk01_b1", b1, 8'hFF);
    bus.bank_en = 2'b10;
    #1;
    chk("bk10_b0", b0, 8'hFF);
    chk("bk10_b1", b1, 8'h0A);
    bus.bank_en = 2'b11;
    #1;
    chk("bk11_b0", b0, 8'h0A);
    chk("bk11_b1", b1, 8'h0A);
    bus.bank_en = 2'b01;
    step();
    chk("bk_next", b0, 8'h0B);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
